// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e    : fetch controller states
//   RESET_PC_DEFAULT : PC loaded on reset unless overridden
//   INSTR_W          : instruction word width
//   PC_INC           : sequential PC step
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    ST_REQ,      // ready to issue a request for the current pc
    ST_WAIT,     // one request outstanding, waiting for its response
    ST_HOLD,     // word received but the queue could not take it yet
    ST_DISCARD   // request outstanding whose response must be thrown away
  } fetch_state_e;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_if.sv
// Instruction-memory and instruction-queue signals of the fetch unit.
//   imem_req/imem_addr          : request valid and address (fetch -> memory)
//   imem_ready                  : memory accepts the request
//   imem_resp_valid/resp_data   : response strobe and instruction word
//   queue_full                  : downstream queue cannot accept a push
//   enque/enque_data            : push strobe and {pc, instr} payload
// master = fetch unit side, slave = memory/queue side.
interface fetch_unit_if #(
  parameter int WIDTH = 64
);
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_ready;
  logic              imem_resp_valid;
  logic [31:0]       imem_resp_data;
  logic              queue_full;
  logic              enque;
  logic [WIDTH-1:0]  enque_data;

  modport master (
    output imem_req, imem_addr, enque, enque_data,
    input  imem_ready, imem_resp_valid, imem_resp_data, queue_full
  );

  modport slave (
    input  imem_req, imem_addr, enque, enque_data,
    output imem_ready, imem_resp_valid, imem_resp_data, queue_full
  );
endinterface : fetch_unit_if

// File: rtl/fetch_pc_gen.sv
// Fetch PC register with sequential increment and redirect load.
//   clk, reset  : clock, synchronous active-high reset (loads RESET_PC)
//   load_i      : take load_pc_i (redirect); wins over inc_i
//   load_pc_i   : redirect target
//   inc_i       : advance to pc + 4 (32-bit wrap)
//   pc_o        : current fetch PC
module fetch_pc_gen
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_INC;  // modulo 2^32, 0xFFFF_FFFC wraps to 0
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : fetch_pc_gen

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time
// for the current PC and pushes {pc, instr} into the instruction queue.
//   clk, reset   : clock, synchronous active-high reset
//   stall        : blocks new requests and pushes
//   flush        : redirect strobe, highest priority after reset
//   redirect_pc  : new fetch PC, valid with flush
//   bus          : memory request/response and queue push signals
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          WIDTH    = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic [31:0]  redirect_pc,
  fetch_unit_if.master bus
);

  fetch_state_e         state_q, state_d;
  logic [INSTR_W-1:0]   hold_q, hold_d;
  logic [31:0]          pc;
  logic                 pc_load, pc_inc;
  logic                 mem_req, push;
  logic [INSTR_W-1:0]   push_instr;
  logic                 can_push;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk       (clk),
    .reset     (reset),
    .load_i    (pc_load),
    .load_pc_i (redirect_pc),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  assign can_push = ~bus.queue_full & ~stall;

  // Outputs are decoded from state and the live inputs so that a response can
  // be pushed in the cycle it arrives; everything is forced idle under reset.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    mem_req    = 1'b0;
    push       = 1'b0;
    push_instr = hold_q;

    if (!reset) begin
      unique case (state_q)
        ST_REQ: begin
          if (flush) begin
            pc_load = 1'b1;
          end else begin
            mem_req = ~stall;
            if (mem_req && bus.imem_ready) state_d = ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (flush) begin
            // A response in the flush cycle retires the request; otherwise it
            // is still in flight and must be swallowed later.
            pc_load = 1'b1;
            state_d = bus.imem_resp_valid ? ST_REQ : ST_DISCARD;
          end else if (bus.imem_resp_valid) begin
            if (can_push) begin
              push       = 1'b1;
              push_instr = bus.imem_resp_data;
              pc_inc     = 1'b1;
              state_d    = ST_REQ;
            end else begin
              hold_d  = bus.imem_resp_data;
              state_d = ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (flush) begin
            pc_load = 1'b1;
            hold_d  = '0;
            state_d = ST_REQ;
          end else if (can_push) begin
            push    = 1'b1;
            pc_inc  = 1'b1;
            hold_d  = '0;
            state_d = ST_REQ;
          end
        end

        ST_DISCARD: begin
          if (flush) pc_load = 1'b1;
          // The stale response retires the request whether or not another
          // redirect arrives with it.
          if (bus.imem_resp_valid) state_d = ST_REQ;
        end

        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_REQ;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.imem_req   = mem_req;
  assign bus.imem_addr  = pc;
  assign bus.enque      = push;
  assign bus.enque_data = push ? WIDTH'({pc, push_instr}) : '0;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, plus a transaction-level model checked every cycle.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit_if #(.WIDTH(64)) bus ();

  fetch_unit #(
    .RESET_PC (RST_PC),
    .WIDTH    (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: one request may be in flight (possibly marked for dropping) and at
  // most one received word may be waiting for the queue.
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc       = '0;
  bit          m_inflight = 1'b0;
  bit          m_drop     = 1'b0;
  logic [31:0] m_held[$];

  always @(negedge clk) begin
    logic        e_req, e_enq, ok_to_push, live_resp;
    logic [63:0] e_data;

    live_resp  = m_inflight && !m_drop && bus.imem_resp_valid;
    ok_to_push = !reset && !flush && !stall && !bus.queue_full;
    e_req      = !reset && !flush && !stall && !m_inflight && (m_held.size() == 0);
    if (m_held.size() != 0) begin
      e_enq  = ok_to_push;
      e_data = {m_pc, m_held[0]};
    end else begin
      e_enq  = ok_to_push && live_resp;
      e_data = {m_pc, bus.imem_resp_data};
    end
    if (!e_enq) e_data = '0;

    check("mdl_imem_req", {63'd0, bus.imem_req}, {63'd0, e_req});
    if (e_req) check("mdl_imem_addr", {32'd0, bus.imem_addr}, {32'd0, m_pc});
    check("mdl_enque", {63'd0, bus.enque}, {63'd0, e_enq});
    check("mdl_enque_data", bus.enque_data, e_data);

    // Inputs hold until after the next rising edge, so advance the model now.
    if (reset) begin
      m_pc = RST_PC; m_inflight = 0; m_drop = 0; m_held.delete();
    end else if (flush) begin
      m_pc = redirect_pc;
      m_held.delete();
      if (m_inflight && !bus.imem_resp_valid) m_drop = 1;
      else begin m_inflight = 0; m_drop = 0; end
    end else if (m_held.size() != 0) begin
      if (e_enq) begin void'(m_held.pop_front()); m_pc = m_pc + 32'd4; end
    end else if (m_inflight) begin
      if (bus.imem_resp_valid) begin
        m_inflight = 0;
        if (m_drop) m_drop = 0;
        else if (e_enq) m_pc = m_pc + 32'd4;
        else m_held.push_back(bus.imem_resp_data);
      end
    end else if (e_req && bus.imem_ready) begin
      m_inflight = 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus; inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input logic v, input logic [31:0] d);
    bus.imem_resp_valid = v;
    bus.imem_resp_data  = d;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; redirect_pc = '0;
    bus.imem_ready = 1; bus.imem_resp_valid = 0; bus.imem_resp_data = '0;
    bus.queue_full = 0;

    // Reset holds all outputs low.
    step(); step();
    check("rst_req", {63'd0, bus.imem_req}, 64'd0);
    check("rst_enque", {63'd0, bus.enque}, 64'd0);
    check("rst_data", bus.enque_data, 64'd0);

    // Basic fetch with a one-cycle response.
    reset = 0; #1;
    check("f1_req", {63'd0, bus.imem_req}, 64'd1);
    check("f1_addr", {32'd0, bus.imem_addr}, 64'h0000_0000_BFC0_0000);
    step();
    resp(1, 32'h1111_1111); #1;
    check("f1_enque", {63'd0, bus.enque}, 64'd1);
    check("f1_data", bus.enque_data, 64'hBFC0_0000_1111_1111);
    check("f1_no_req", {63'd0, bus.imem_req}, 64'd0);
    step();
    resp(0, '0); #1;
    check("f1_next_addr", {32'd0, bus.imem_addr}, 64'h0000_0000_BFC0_0004);
    check("f1_next_req", {63'd0, bus.imem_req}, 64'd1);

    // Queue full at response time: hold, then push after it clears.
    step();
    resp(1, 32'h2222_2222); bus.queue_full = 1; #1;
    check("hold_no_enque", {63'd0, bus.enque}, 64'd0);
    step();
    resp(0, '0); #1;
    check("hold_no_req", {63'd0, bus.imem_req}, 64'd0);
    step(); step();
    bus.queue_full = 0; #1;
    check("hold_enque", {63'd0, bus.enque}, 64'd1);
    check("hold_data", bus.enque_data, 64'hBFC0_0004_2222_2222);
    step();
    check("hold_next_addr", {32'd0, bus.imem_addr}, 64'h0000_0000_BFC0_0008);

    // Flush while waiting; late response must be dropped.
    step();
    flush = 1; redirect_pc = 32'h0040_0000; #1;
    check("fw_no_req", {63'd0, bus.imem_req}, 64'd0);
    step();
    flush = 0; #1;
    check("disc_no_req", {63'd0, bus.imem_req}, 64'd0);
    step();
    resp(1, 32'h3333_3333); #1;
    check("disc_no_enque", {63'd0, bus.enque}, 64'd0);
    step();
    resp(0, '0); #1;
    check("disc_next_addr", {32'd0, bus.imem_addr}, 64'h0000_0000_0040_0000);
    check("disc_next_req", {63'd0, bus.imem_req}, 64'd1);
    step();
    resp(1, 32'h4444_4444); #1;
    check("redir_data", bus.enque_data, 64'h0040_0000_4444_4444);
    step();
    resp(0, '0);

    // Flush coincident with a response: word dropped, no discard phase.
    step();
    resp(1, 32'h5555_0000); flush = 1; redirect_pc = 32'h0050_0000; #1;
    check("fr_no_enque", {63'd0, bus.enque}, 64'd0);
    step();
    resp(0, '0); flush = 0; #1;
    check("fr_req", {63'd0, bus.imem_req}, 64'd1);
    check("fr_addr", {32'd0, bus.imem_addr}, 64'h0000_0000_0050_0000);

    // PC wrap at the top of the address space.
    flush = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    flush = 0; #1;
    check("wrap_addr0", {32'd0, bus.imem_addr}, 64'h0000_0000_FFFF_FFFC);
    step();
    resp(1, 32'h5555_5555); #1;
    check("wrap_data", bus.enque_data, 64'hFFFF_FFFC_5555_5555);
    step();
    resp(0, '0); #1;
    check("wrap_addr1", {32'd0, bus.imem_addr}, 64'd0);

    // Stall in REQ for four cycles, then resume at the same pc.
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_no_req", {63'd0, bus.imem_req}, 64'd0);
      step();
    end
    stall = 0;
    bus.imem_ready = 0; #1;
    check("stall_resume_req", {63'd0, bus.imem_req}, 64'd1);
    check("stall_resume_addr", {32'd0, bus.imem_addr}, 64'd0);
    step();
    bus.imem_ready = 1; #1;
    check("notready_req", {63'd0, bus.imem_req}, 64'd1);

    // Stall at response time routes through the hold register.
    step();
    resp(1, 32'h6666_6666); stall = 1; #1;
    check("stall_resp_no_enque", {63'd0, bus.enque}, 64'd0);
    step();
    resp(0, '0); stall = 0; #1;
    check("stall_hold_data", bus.enque_data, 64'h0000_0000_6666_6666);
    step();
    check("stall_next_addr", {32'd0, bus.imem_addr}, 64'h0000_0000_0000_0004);

    // Flush while holding a word.
    step();
    resp(1, 32'h7777_7777); bus.queue_full = 1;
    step();
    resp(0, '0); flush = 1; redirect_pc = 32'h0060_0000; bus.queue_full = 0; #1;
    check("fh_no_enque", {63'd0, bus.enque}, 64'd0);
    step();
    flush = 0; #1;
    check("fh_addr", {32'd0, bus.imem_addr}, 64'h0000_0000_0060_0000);
    check("fh_req", {63'd0, bus.imem_req}, 64'd1);

    // Reset in the middle of a wait.
    step();
    reset = 1; #1;
    check("rw_no_req", {63'd0, bus.imem_req}, 64'd0);
    step();
    reset = 0; #1;
    check("rw_req", {63'd0, bus.imem_req}, 64'd1);
    check("rw_addr", {32'd0, bus.imem_addr}, 64'h0000_0000_BFC0_0000);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_unit
